// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame FSM state encoding
// and the fixed line levels of the start, stop and idle bits.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter of the UART transmit framer.
// Holds the latched word, shifts it right one bit per shift_en and flags the
// cycle in which the last data bit is on the line (ser_done).
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             lsb,
  output logic             next_lsb,
  output logic             ser_done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;

  // Load on accept, otherwise shift and count; counter wraps to 0 after the last bit
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shreg_q <= load_data;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
      cnt_q   <= ser_done ? '0 : cnt_q + 1'b1;
    end
  end

  assign lsb      = shreg_q[0];
  // Bit that becomes the LSB after this cycle's shift; feeds the registered line
  assign next_lsb = shreg_q[1];
  assign ser_done = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framing stage: start bit, WIDTH data bits LSB-first, optional
// parity bit and stop bit, one bit per CLK. TX_OUT and BUSY are registered,
// so both are computed from the next state.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_BIT,
  output logic             TX_OUT,
  output logic             BUSY
);

  tx_state_e state_q, state_d;
  logic      par_q, par_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      load, shift_en;
  logic      lsb, next_lsb, ser_done;
  logic      stop_last;

  uart_tx_serializer #(
    .WIDTH(WIDTH)
  ) u_serializer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift_en (shift_en),
    .load_data(P_DATA),
    .lsb      (lsb),
    .next_lsb (next_lsb),
    .ser_done (ser_done)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt_q, stop_cnt_d;

  // Counts the two stop cycles; only the second one is an accept window
  always_ff @(posedge CLK) begin
    if (!RST) begin
      stop_cnt_q <= 1'b0;
    end else begin
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign stop_last = stop_cnt_q;
`else
  assign stop_last = 1'b1;
`endif

  // Frame state, latched parity enable and registered line outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, serializer control and the line level for the next cycle
  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    tx_d     = IDLE_LEVEL;
    load     = 1'b0;
    shift_en = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d = START;
          load    = 1'b1;
          par_d   = PAR_EN;
          tx_d    = START_LEVEL;
        end else begin
          tx_d = IDLE_LEVEL;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = lsb;
      end
      DATA: begin
        shift_en = 1'b1;
        if (ser_done) begin
          if (par_q) begin
            state_d = PARITY;
            tx_d    = PAR_BIT;
          end else begin
            state_d = STOP;
            tx_d    = STOP_LEVEL;
          end
        end else begin
          tx_d = next_lsb;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_LEVEL;
      end
      STOP: begin
        if (!stop_last) begin
          state_d = STOP;
          tx_d    = STOP_LEVEL;
`ifdef UART_TX_TWO_STOP_EN
          stop_cnt_d = 1'b1;
`endif
        end else if (DATA_VALID) begin
          // Back-to-back frame: start bit follows the stop bit directly
          state_d = START;
          load    = 1'b1;
          par_d   = PAR_EN;
          tx_d    = START_LEVEL;
        end else begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame (WIDTH=8). Expected line
// sequences are hand-written in time order, single stop bit; extra stop
// cycles are appended when UART_TX_TWO_STOP_EN is defined.
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
  localparam int StopN = 2;
`else
  localparam int StopN = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_BIT;
  logic       TX_OUT;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_frame #(
    .WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_BIT   (PAR_BIT),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq holds the single-stop frame in time order (first bit is seq[len-1]).
  // Optionally accepts the frame first; DATA_VALID is high in frame cycles
  // dv_lo..dv_hi, carrying nd/np on P_DATA/PAR_EN.
  task automatic run_seq(input string tag, input bit accept, input logic [7:0] d,
                         input logic pe, input logic [31:0] seq, input int len,
                         input int dv_lo, input int dv_hi, input logic [7:0] nd,
                         input logic np);
    int  len_eff;
    logic exp_bit;
    len_eff = len + StopN - 1;
    if (accept) begin
      P_DATA     = d;
      PAR_EN     = pe;
      DATA_VALID = 1'b1;
      tick();
      DATA_VALID = 1'b0;
    end
    for (int i = 0; i < len_eff; i++) begin
      exp_bit = (i < len) ? seq[len-1-i] : 1'b1;
      check($sformatf("%s tx%0d", tag, i), 32'(TX_OUT), 32'(exp_bit));
      check($sformatf("%s busy%0d", tag, i), 32'(BUSY), 32'd1);
      DATA_VALID = (i >= dv_lo) && (i <= dv_hi);
      if (DATA_VALID) begin
        P_DATA = nd;
        PAR_EN = np;
      end
      tick();
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, 32'(TX_OUT), 32'd1);
    check({tag, " busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_BIT    = 1'b0;
    tick();
    tick();
    check_idle("reset");
    RST = 1'b1;
    tick();
    check_idle("idle");

    // 0xA5 with parity, parity bit 0 and then 1
    PAR_BIT = 1'b0;
    run_seq("a5p0", 1'b1, 8'hA5, 1'b1, 32'b01010010101, 11, 99, 99, 8'h00, 1'b0);
    check_idle("a5p0 end");
    PAR_BIT = 1'b1;
    run_seq("a5p1", 1'b1, 8'hA5, 1'b1, 32'b01010010111, 11, 99, 99, 8'h00, 1'b0);
    check_idle("a5p1 end");

    // 0x3C without parity
    PAR_BIT = 1'b0;
    run_seq("3c", 1'b1, 8'h3C, 1'b0, 32'b0001111001, 10, 99, 99, 8'h00, 1'b0);
    check_idle("3c end");

    // Back-to-back 0xFF then 0x00; DATA_VALID covers every stop cycle
    run_seq("ff", 1'b1, 8'hFF, 1'b0, 32'b0111111111, 10, 9, 10 + StopN - 2, 8'h00, 1'b0);
    run_seq("00", 1'b0, 8'h00, 1'b0, 32'b0000000001, 10, 99, 99, 8'h00, 1'b0);
    check_idle("b2b end");

    // DATA_VALID, P_DATA and PAR_EN disturbed during DATA: frame unchanged
    run_seq("dist", 1'b1, 8'h3C, 1'b0, 32'b0001111001, 10, 2, 5, 8'hFF, 1'b1);
    check_idle("dist end");
    tick();
    check_idle("dist gap");

    // Reset in the middle of DATA, then a clean frame
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b1;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b0;
    tick();
    check_idle("midrst");
    RST = 1'b1;
    run_seq("clean", 1'b1, 8'h3C, 1'b0, 32'b0001111001, 10, 99, 99, 8'h00, 1'b0);
    check_idle("clean end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Transmit framing stage of the UART TX path: FSM, shift register and output mux.
- Consumes the parallel word and the parity bit produced by the parity calculator.
- Emits the serial line TX_OUT: start bit, data LSB-first, optional parity bit, stop bit.
- CLK is the TX bit clock; one frame bit is driven per CLK cycle.

Parameters:
WIDTH, 8, data word width in bits (≥2)

Ports:
CLK  input  1  TX bit clock, rising-edge
RST  input  1  reset, synchronous, active-low
P_DATA  input  WIDTH  parallel data word, sampled on accept
DATA_VALID  input  1  request to send P_DATA
PAR_EN  input  1  1 = insert parity bit; sampled on accept
PAR_BIT  input  1  parity bit from the parity calculator; used in PARITY state
TX_OUT  output  1  serial line, registered, idle high
BUSY  output  1  registered; high while a frame is on the line

Behaviour:
- Reset (RST=0 at a rising edge, any state including mid-frame):
  - Next cycle: state IDLE, TX_OUT=1, BUSY=0.
  - Shift register and bit counter cleared; in-progress frame is dropped.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept rule: DATA_VALID=1 at an edge while in IDLE, or in the final STOP cycle.
  - Latch P_DATA into the shift register and PAR_EN into the parity flag; go to START.
- Latency: accept at edge N, so TX_OUT=0 (start bit) and BUSY=1 from cycle N+1.
- START (1 cycle) → DATA. TX_OUT = shreg[0].
- DATA (WIDTH cycles): TX_OUT = current LSB, shift right each cycle; counter 0..WIDTH-1.
  - After the last bit: → PARITY if the latched flag is 1, else → STOP.
- PARITY (1 cycle): TX_OUT = PAR_BIT as sampled at the edge entering PARITY → STOP.
- STOP (1 cycle): TX_OUT=1.
  - If DATA_VALID=1 at the end of STOP: accept, → START. No idle gap between frames.
  - Otherwise → IDLE with BUSY=0.
- Frame length: WIDTH+2 cycles, or WIDTH+3 with parity. BUSY is high for exactly that many cycles.
- DATA_VALID outside the accept windows is ignored. P_DATA and PAR_EN changes mid-frame have no effect.
- PAR_BIT is not latched at accept. Upstream must hold it stable from accept until the PARITY cycle; the parity calculator holds its sampled value, which satisfies this.
- Counter width: $clog2(WIDTH). Counter wraps to 0 on leaving DATA.
- Unreachable state encodings → IDLE with TX_OUT=1.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined:
  - STOP lasts 2 cycles, both TX_OUT=1; frame length grows by 1.
  - Accept window is the second STOP cycle only.
  - Requires a 1-bit stop counter.
- Undefined: single STOP cycle exactly as above; no stop counter is synthesised.

Decomposition:
- Shared package uart_tx_pkg holds:
  - State encoding enum: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits.
  - Constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One natural sub-module: uart_tx_serializer.
  - Contents: WIDTH shift register, bit counter, ser_done flag.
  - Control inputs: load, shift_en.
- FSM and TX_OUT mux stay in uart_tx_frame.

Test Plan:
- Reset mid-DATA with RST=0 for 1 cycle → next cycle TX_OUT=1, BUSY=0; DATA_VALID one cycle later starts a clean frame.
- WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_BIT=0, 1-cycle DATA_VALID → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; BUSY high 11 cycles then 0.
- P_DATA=0x3C, PAR_EN=0 → TX_OUT 0,0,0,1,1,1,1,0,0,1 (10 cycles); no parity cycle.
- Back-to-back: 0xFF then 0x00, second DATA_VALID asserted in the STOP cycle → second start bit on the very next cycle; BUSY never drops.
- DATA_VALID pulsed and P_DATA/PAR_EN toggled during DATA → current frame bits unchanged; no extra frame after STOP unless DATA_VALID is high in STOP.
- With UART_TX_TWO_STOP_EN, P_DATA=0xA5, PAR_EN=1 → 12-cycle frame ending 1,1; DATA_VALID in the first STOP cycle is ignored.
